// File: rtl/input_fifo_bank_pkg.sv
// Shared definitions for the input FIFO bank and the arbiter that consumes it.
//   FIFO_UNITS    : number of input lanes
//   WORD_SIZE_DEF : default buffered word width
//   clog2()       : ceiling log2, sizes pointers and occupancy counts
package input_fifo_bank_pkg;

  localparam int FIFO_UNITS    = 4;
  localparam int WORD_SIZE_DEF = 12;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_lane.sv
// Single synchronous FIFO lane with first-word-fall-through read data.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   push, wr_data : write strobe and data
//   pop           : remove the head word
//   rd_data       : head word (combinational), 0 while empty
//   empty, almost_full, full : registered occupancy flags
//   error         : sticky overflow/underflow indicator, cleared only by reset
//
// Handshake: push and pop are single-cycle strobes with no ready/ack. The writer
// watches almost_full (and full) and must stop pushing; the reader watches empty.
// A push into a full lane without a simultaneous pop, or a pop from an empty
// lane without a simultaneous push, is dropped and latches error.
module fifo_lane
  import input_fifo_bank_pkg::*;
#(
  parameter int WORD_SIZE       = WORD_SIZE_DEF,
  parameter int FIFO_DEPTH      = 8,
  parameter int ALMOST_FULL_LVL = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 pop,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 full,
  output logic                 error
);

  localparam int PW = clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_LVL);
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);

  logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_nxt;
  logic                 do_push;
  logic                 do_pop;
  logic                 overflow;
  logic                 underflow;

  // A full lane still accepts a push when a pop frees the head slot in the
  // same cycle; an empty lane ignores the pop but still takes the push.
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;
  assign overflow  = push && full && !pop;
  assign underflow = pop && empty && !push;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + CNT_ONE;
    else if (!do_push && do_pop)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      full        <= 1'b0;
      error       <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      almost_full <= (count_nxt >= AF_LVL);
      full        <= (count_nxt == FULL_LVL);
      if (overflow || underflow) error <= 1'b1;
    end
  end

  // Storage is not reset; a reset only rewinds the pointers, which discards
  // the contents logically.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/input_fifo_bank.sv
// Four independent input FIFO lanes feeding the 4-lane arbiter.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   fifos_push[i]       : write fifo_wr_data<i> into lane i
//   fifo_wr_data0..3    : write data per lane
//   fifos_pop[i]        : remove head word of lane i (driven by the arbiter)
//   fifo_data_in0..3    : head word per lane (first-word-fall-through), 0 if empty
//   fifos_empty/almost_full/full/error : per-lane flags, error is sticky
// The top only splits the buses onto the lanes; nothing crosses lanes.
module input_fifo_bank
  import input_fifo_bank_pkg::*;
#(
  parameter int WORD_SIZE       = WORD_SIZE_DEF,
  parameter int FIFO_DEPTH      = 8,
  parameter int ALMOST_FULL_LVL = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FIFO_UNITS-1:0] fifos_push,
  input  logic [WORD_SIZE-1:0]  fifo_wr_data0,
  input  logic [WORD_SIZE-1:0]  fifo_wr_data1,
  input  logic [WORD_SIZE-1:0]  fifo_wr_data2,
  input  logic [WORD_SIZE-1:0]  fifo_wr_data3,
  input  logic [FIFO_UNITS-1:0] fifos_pop,
  output logic [WORD_SIZE-1:0]  fifo_data_in0,
  output logic [WORD_SIZE-1:0]  fifo_data_in1,
  output logic [WORD_SIZE-1:0]  fifo_data_in2,
  output logic [WORD_SIZE-1:0]  fifo_data_in3,
  output logic [FIFO_UNITS-1:0] fifos_empty,
  output logic [FIFO_UNITS-1:0] fifos_almost_full,
  output logic [FIFO_UNITS-1:0] fifos_full,
  output logic [FIFO_UNITS-1:0] fifos_error
);

  logic [WORD_SIZE-1:0] wr_data [FIFO_UNITS];
  logic [WORD_SIZE-1:0] rd_data [FIFO_UNITS];

  assign wr_data[0] = fifo_wr_data0;
  assign wr_data[1] = fifo_wr_data1;
  assign wr_data[2] = fifo_wr_data2;
  assign wr_data[3] = fifo_wr_data3;

  assign fifo_data_in0 = rd_data[0];
  assign fifo_data_in1 = rd_data[1];
  assign fifo_data_in2 = rd_data[2];
  assign fifo_data_in3 = rd_data[3];

  for (genvar i = 0; i < FIFO_UNITS; i++) begin : g_lane
    fifo_lane #(
      .WORD_SIZE       (WORD_SIZE),
      .FIFO_DEPTH      (FIFO_DEPTH),
      .ALMOST_FULL_LVL (ALMOST_FULL_LVL)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .push        (fifos_push[i]),
      .wr_data     (wr_data[i]),
      .pop         (fifos_pop[i]),
      .rd_data     (rd_data[i]),
      .empty       (fifos_empty[i]),
      .almost_full (fifos_almost_full[i]),
      .full        (fifos_full[i]),
      .error       (fifos_error[i])
    );
  end

endmodule

// File: tb/tb_input_fifo_bank.sv
module tb_input_fifo_bank;

  localparam int W     = 12;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]   push, pop;
  logic [W-1:0] wd0, wd1, wd2, wd3;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   empty, afull, full, err;
  logic [W-1:0] dout [4];

  assign dout[0] = d0;
  assign dout[1] = d1;
  assign dout[2] = d2;
  assign dout[3] = d3;

  input_fifo_bank dut (
    .clk               (clk),
    .reset             (reset),
    .fifos_push        (push),
    .fifo_wr_data0     (wd0),
    .fifo_wr_data1     (wd1),
    .fifo_wr_data2     (wd2),
    .fifo_wr_data3     (wd3),
    .fifos_pop         (pop),
    .fifo_data_in0     (d0),
    .fifo_data_in1     (d1),
    .fifo_data_in2     (d2),
    .fifo_data_in3     (d3),
    .fifos_empty       (empty),
    .fifos_almost_full (afull),
    .fifos_full        (full),
    .fifos_error       (err)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [4][$];
  logic [3:0]   exp_err;
  int           n_vec  = 0;
  int           n_miss = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic [3:0] pu, input logic [3:0] po,
                              input logic [3:0][W-1:0] wd);
    if (rst) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
      exp_err = '0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (pu[i] && po[i]) begin
        if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
        exp_q[i].push_back(wd[i]);
      end else if (pu[i]) begin
        if (exp_q[i].size() == DEPTH) exp_err[i] = 1'b1;
        else exp_q[i].push_back(wd[i]);
      end else if (po[i]) begin
        if (exp_q[i].size() == 0) exp_err[i] = 1'b1;
        else void'(exp_q[i].pop_front());
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      int sz;
      sz = exp_q[i].size();
      check($sformatf("empty%0d", i), 48'(empty[i]), 48'(sz == 0));
      check($sformatf("afull%0d", i), 48'(afull[i]), 48'(sz >= AF));
      check($sformatf("full%0d", i),  48'(full[i]),  48'(sz == DEPTH));
      check($sformatf("err%0d", i),   48'(err[i]),   48'(exp_err[i]));
      check($sformatf("data%0d", i),  48'(dout[i]),  48'((sz == 0) ? '0 : exp_q[i][0]));
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of stimulus, advances the model at the same edge and
  // leaves the bench sampling #1 after that edge.
  task automatic step(input logic rst, input logic [3:0] pu, input logic [3:0] po,
                      input logic [3:0][W-1:0] wd);
    @(negedge clk);
    reset = rst;
    push  = pu;
    pop   = po;
    wd0 = wd[0]; wd1 = wd[1]; wd2 = wd[2]; wd3 = wd[3];
    @(posedge clk);
    model_update(rst, pu, po, wd);
    #1;
    reset = 1'b0;
    push  = '0;
    pop   = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]        push;
    logic [3:0]        pop;
    logic [3:0][W-1:0] wd;
    logic [3:0]        e_empty;
    logic [3:0]        e_err;
    logic [3:0][W-1:0] e_data;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(input logic [3:0] pu, input logic [3:0] po, input logic [47:0] wd,
                              input logic [3:0] ee, input logic [3:0] er, input logic [47:0] ed);
    vec_t v;
    v.push = pu; v.pop = po; v.wd = wd;
    v.e_empty = ee; v.e_err = er; v.e_data = ed;
    return v;
  endfunction

  initial begin
    logic [3:0][W-1:0] z;
    logic [3:0][W-1:0] w;
    z = '0;
    reset = 1'b1;
    push = '0; pop = '0;
    wd0 = '0; wd1 = '0; wd2 = '0; wd3 = '0;
    exp_err = '0;

    // lane0 FIFO order, then lane3 empty push+pop and underflow
    vecs[0] = mk(4'b0001, 4'b0000, {36'h0, 12'hA01}, 4'b1110, 4'b0000, {36'h0, 12'hA01});
    vecs[1] = mk(4'b0001, 4'b0000, {36'h0, 12'hA02}, 4'b1110, 4'b0000, {36'h0, 12'hA01});
    vecs[2] = mk(4'b0001, 4'b0000, {36'h0, 12'hA03}, 4'b1110, 4'b0000, {36'h0, 12'hA01});
    vecs[3] = mk(4'b0000, 4'b0001, 48'h0,            4'b1110, 4'b0000, {36'h0, 12'hA02});
    vecs[4] = mk(4'b0000, 4'b0001, 48'h0,            4'b1110, 4'b0000, {36'h0, 12'hA03});
    vecs[5] = mk(4'b0000, 4'b0001, 48'h0,            4'b1111, 4'b0000, 48'h0);
    vecs[6] = mk(4'b1000, 4'b1000, {12'h0C3, 36'h0}, 4'b0111, 4'b0000, {12'h0C3, 36'h0});
    vecs[7] = mk(4'b0000, 4'b1000, 48'h0,            4'b1111, 4'b0000, 48'h0);
    vecs[8] = mk(4'b0000, 4'b1000, 48'h0,            4'b1111, 4'b1000, 48'h0);

    // reset for 2 cycles
    step(1'b1, '0, '0, z);
    step(1'b1, '0, '0, z);
    check("rst_empty", 48'(empty), 48'hF);
    check("rst_afull", 48'(afull), 48'h0);
    check("rst_full",  48'(full),  48'h0);
    check("rst_err",   48'(err),   48'h0);
    check("rst_data",  {d3, d2, d1, d0}, 48'h0);

    for (int v = 0; v < 9; v++) begin
      step(1'b0, vecs[v].push, vecs[v].pop, vecs[v].wd);
      check($sformatf("vec%0d_empty", v), 48'(empty), 48'(vecs[v].e_empty));
      check($sformatf("vec%0d_err", v),   48'(err),   48'(vecs[v].e_err));
      check($sformatf("vec%0d_data", v),  {d3, d2, d1, d0}, 48'(vecs[v].e_data));
      check($sformatf("vec%0d_full", v),  48'(full),  48'h0);
    end

    // lane1 fill to full, overflow, drain
    for (int k = 0; k < DEPTH; k++) begin
      w = z; w[1] = W'(12'h200 + k);
      step(1'b0, 4'b0010, 4'b0000, w);
      check($sformatf("fill1_af_%0d", k + 1),   48'(afull[1]), 48'((k + 1) >= 6));
      check($sformatf("fill1_full_%0d", k + 1), 48'(full[1]),  48'((k + 1) == 8));
      check_all();
    end
    w = z; w[1] = 12'hFFF;
    step(1'b0, 4'b0010, 4'b0000, w);
    check("ovf1_err",  48'(err[1]),  48'h1);
    check("ovf1_full", 48'(full[1]), 48'h1);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("drain1_%0d", k), 48'(d1), 48'(12'h200 + k));
      step(1'b0, 4'b0000, 4'b0010, z);
      check_all();
    end
    check("drain1_empty", 48'(empty[1]), 48'h1);

    // lane2 full: simultaneous push+pop
    for (int k = 0; k < DEPTH; k++) begin
      w = z; w[2] = W'(12'h300 + k);
      step(1'b0, 4'b0100, 4'b0000, w);
    end
    check_all();
    w = z; w[2] = 12'h555;
    step(1'b0, 4'b0100, 4'b0100, w);
    check("pp2_full", 48'(full[2]), 48'h1);
    check("pp2_err",  48'(err[2]),  48'h0);
    check_all();
    for (int k = 1; k < DEPTH; k++) begin
      check($sformatf("drain2_%0d", k), 48'(d2), 48'(12'h300 + k));
      step(1'b0, 4'b0000, 4'b0100, z);
    end
    check("drain2_last", 48'(d2), 48'h555);
    step(1'b0, 4'b0000, 4'b0100, z);
    check_all();

    // lane0 wrap: 20 push/pop pairs
    w = z; w[0] = 12'h100;
    step(1'b0, 4'b0001, 4'b0000, w);
    for (int k = 1; k < 20; k++) begin
      check($sformatf("wrap0_%0d", k - 1), 48'(d0), 48'(12'h100 + k - 1));
      w = z; w[0] = W'(12'h100 + k);
      step(1'b0, 4'b0001, 4'b0001, w);
    end
    check("wrap0_19", 48'(d0), 48'h113);
    step(1'b0, 4'b0000, 4'b0001, z);
    check_all();

    // partial fill of all lanes, then reset mid-operation
    for (int k = 0; k < 3; k++) begin
      w[0] = W'(12'h010 + k); w[1] = W'(12'h020 + k);
      w[2] = W'(12'h030 + k); w[3] = W'(12'h040 + k);
      step(1'b0, 4'hF, 4'h0, w);
    end
    check_all();
    step(1'b1, '0, '0, z);
    check("mid_rst_empty", 48'(empty), 48'hF);
    check("mid_rst_err",   48'(err),   48'h0);
    check("mid_rst_data",  {d3, d2, d1, d0}, 48'h0);
    check_all();

    // random 4-lane traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) w[i] = W'($urandom_range(0, 4095));
      step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), w);
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
